// File: rtl/retire_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module   : retire_trace_monitor
// Brief    : Run control and retirement trace for the pipelined RISC-V core.
//            Counts RUN cycles and register-write retirements, queues each
//            retirement as a {cycle, addr, data} record in a FIFO, and ends
//            the run on halt (PC stalled) or on a cycle timeout.
//            Optional shadow register file: define RETIRE_TRACE_SHADOW_RF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module retire_trace_monitor #(
    parameter int XLEN        = 32,
    parameter int RADDR_W     = 5,
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 32,
    parameter int MAX_CYCLES  = 1000,
    parameter int HALT_REPEAT = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [XLEN-1:0]    pc_out,
    input  logic               Regwrite_MEM_WB,
    input  logic [RADDR_W-1:0] write_address_MEM_WB,
    input  logic [XLEN-1:0]    final_result,
    input  logic               trace_ready,
    output logic               trace_valid,
    output logic [CNT_W-1:0]   trace_cycle,
    output logic [RADDR_W-1:0] trace_addr,
    output logic [XLEN-1:0]    trace_data,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [CNT_W-1:0]   retire_count,
    output logic               overflow,
    output logic [1:0]         state,
`ifdef RETIRE_TRACE_SHADOW_RF_EN
    input  logic [RADDR_W-1:0] shadow_addr,
    output logic [XLEN-1:0]    shadow_data,
`endif
    output logic               done
);

    localparam logic [1:0] c_ST_IDLE    = 2'b00;
    localparam logic [1:0] c_ST_RUN     = 2'b01;
    localparam logic [1:0] c_ST_HALTED  = 2'b10;
    localparam logic [1:0] c_ST_TIMEOUT = 2'b11;

    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_SAME_W = $clog2(HALT_REPEAT + 1);
    localparam int c_REC_W  = CNT_W + RADDR_W + XLEN;

    localparam logic [CNT_W-1:0]    c_MAX_CNT   = CNT_W'(MAX_CYCLES);
    localparam logic [c_SAME_W-1:0] c_HALT_LAST = c_SAME_W'(HALT_REPEAT - 1);
    localparam logic [c_SAME_W-1:0] c_HALT_SAT  = c_SAME_W'(HALT_REPEAT);
    localparam logic [c_PTR_W:0]    c_DEPTH_CNT = (c_PTR_W + 1)'(FIFO_DEPTH);

    // Run-control state
    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_cycle_count;
    logic [CNT_W-1:0]    r_retire_count;
    logic [XLEN-1:0]     r_pc_prev;
    logic [c_SAME_W-1:0] r_same_cnt;

    // Trace FIFO state
    logic [c_REC_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W:0]    r_count;
    logic                r_trace_valid;
    logic [CNT_W-1:0]    r_trace_cycle;
    logic [RADDR_W-1:0]  r_trace_addr;
    logic [XLEN-1:0]     r_trace_data;
    logic                r_overflow;

    logic                w_run;
    logic                w_retire;
    logic                w_pc_match;
    logic                w_halt;
    logic                w_timeout;
    logic [CNT_W-1:0]    w_cycle_inc;
    logic                w_full;
    logic                w_pop;
    logic                w_push_ok;
    logic                w_drop;
    logic [c_PTR_W-1:0]  w_rd_ptr_next;
    logic [c_PTR_W:0]    w_remain;
    logic [c_PTR_W:0]    w_count_next;
    logic [c_REC_W-1:0]  w_push_rec;
    logic [c_REC_W-1:0]  w_head_next;

    assign w_run       = (r_state == c_ST_RUN);
    // x0 writes are architecturally invisible, so they are not retirements
    assign w_retire    = w_run && Regwrite_MEM_WB && (write_address_MEM_WB != '0);
    // First RUN cycle compares against pc_prev=0 on purpose: a core parked at 0 is halted
    assign w_pc_match  = (pc_out == r_pc_prev);
    assign w_halt      = w_run && w_pc_match && (r_same_cnt == c_HALT_LAST);
    assign w_cycle_inc = r_cycle_count + CNT_W'(1);
    // Halt takes priority when both end conditions land on the same edge
    assign w_timeout   = w_run && (w_cycle_inc == c_MAX_CNT) && !w_halt;

    assign w_full        = (r_count == c_DEPTH_CNT);
    assign w_pop         = r_trace_valid && trace_ready;
    // A pop on the same edge frees a slot, so a full FIFO still accepts the push
    assign w_push_ok     = w_retire && (!w_full || w_pop);
    assign w_drop        = w_retire && w_full && !w_pop;
    assign w_rd_ptr_next = w_pop ? (r_rd_ptr + c_PTR_W'(1)) : r_rd_ptr;
    assign w_remain      = r_count - (c_PTR_W + 1)'(w_pop);
    assign w_count_next  = w_remain + (c_PTR_W + 1)'(w_push_ok);
    assign w_push_rec    = {r_cycle_count, write_address_MEM_WB, final_result};

    // Next head record: surviving entry if any, else the incoming record, else hold
    always_comb begin
        w_head_next = {r_trace_cycle, r_trace_addr, r_trace_data};
        if (w_remain != '0) begin
            w_head_next = r_mem[w_rd_ptr_next];
        end else if (w_push_ok) begin
            w_head_next = w_push_rec;
        end
    end

    // Run-control FSM with cycle/retire counters and halt detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= c_ST_IDLE;
            r_cycle_count  <= '0;
            r_retire_count <= '0;
            r_pc_prev      <= '0;
            r_same_cnt     <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (enable) begin
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    r_cycle_count <= w_cycle_inc;
                    r_pc_prev     <= pc_out;
                    if (w_retire) begin
                        r_retire_count <= r_retire_count + CNT_W'(1);
                    end
                    if (w_pc_match) begin
                        if (r_same_cnt != c_HALT_SAT) begin
                            r_same_cnt <= r_same_cnt + c_SAME_W'(1);
                        end
                    end else begin
                        r_same_cnt <= '0;
                    end
                    if (w_halt) begin
                        r_state <= c_ST_HALTED;
                    end else if (w_timeout) begin
                        r_state <= c_ST_TIMEOUT;
                    end
                end
                default: begin
                    // HALTED / TIMEOUT are terminal until reset
                end
            endcase
        end
    end

    // Trace FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_push_rec;
        end
    end

    // Trace FIFO pointers, registered head outputs and sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_trace_valid <= 1'b0;
            r_trace_cycle <= '0;
            r_trace_addr  <= '0;
            r_trace_data  <= '0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            r_rd_ptr      <= w_rd_ptr_next;
            r_count       <= w_count_next;
            r_trace_valid <= (w_count_next != '0);
            {r_trace_cycle, r_trace_addr, r_trace_data} <= w_head_next;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef RETIRE_TRACE_SHADOW_RF_EN
    logic [XLEN-1:0] r_shadow [2**RADDR_W];

    // Shadow register file tracks every retirement, independent of FIFO space
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2**RADDR_W; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_retire) begin
            r_shadow[write_address_MEM_WB] <= final_result;
        end
    end

    assign shadow_data = (shadow_addr == '0) ? '0 : r_shadow[shadow_addr];
`endif

    assign trace_valid  = r_trace_valid;
    assign trace_cycle  = r_trace_cycle;
    assign trace_addr   = r_trace_addr;
    assign trace_data   = r_trace_data;
    assign cycle_count  = r_cycle_count;
    assign retire_count = r_retire_count;
    assign overflow     = r_overflow;
    assign state        = r_state;
    assign done         = r_state[1];

endmodule
`default_nettype wire

// File: tb/tb_retire_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_retire_trace_monitor
// Brief    : Directed self-checking bench for retire_trace_monitor
//            (trace records, x0 filtering, halt, timeout, halt-vs-timeout,
//            FIFO overflow and push-while-full-with-pop, mid-run reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_retire_trace_monitor;

    localparam int c_XLEN = 32;
    localparam int c_RW   = 5;
    localparam int c_CW   = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic [c_XLEN-1:0] pc_out = '0;
    logic              Regwrite_MEM_WB = 1'b0;
    logic [c_RW-1:0]   write_address_MEM_WB = '0;
    logic [c_XLEN-1:0] final_result = '0;
    logic              trace_ready = 1'b0;
    logic              trace_valid;
    logic [c_CW-1:0]   trace_cycle;
    logic [c_RW-1:0]   trace_addr;
    logic [c_XLEN-1:0] trace_data;
    logic [c_CW-1:0]   cycle_count;
    logic [c_CW-1:0]   retire_count;
    logic              overflow;
    logic [1:0]        state;
    logic              done;
`ifdef RETIRE_TRACE_SHADOW_RF_EN
    logic [c_RW-1:0]   shadow_addr = '0;
    logic [c_XLEN-1:0] shadow_data;
`endif

    int checks = 0;
    int errors = 0;

    retire_trace_monitor #(
        .XLEN(c_XLEN), .RADDR_W(c_RW), .FIFO_DEPTH(8), .CNT_W(c_CW),
        .MAX_CYCLES(20), .HALT_REPEAT(3)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .pc_out(pc_out),
        .Regwrite_MEM_WB(Regwrite_MEM_WB),
        .write_address_MEM_WB(write_address_MEM_WB),
        .final_result(final_result), .trace_ready(trace_ready),
        .trace_valid(trace_valid), .trace_cycle(trace_cycle),
        .trace_addr(trace_addr), .trace_data(trace_data),
        .cycle_count(cycle_count), .retire_count(retire_count),
        .overflow(overflow), .state(state),
`ifdef RETIRE_TRACE_SHADOW_RF_EN
        .shadow_addr(shadow_addr), .shadow_data(shadow_data),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [c_RW-1:0] a,
                         input logic [c_XLEN-1:0] d, input logic rdy,
                         input logic [c_XLEN-1:0] pc);
        Regwrite_MEM_WB      = we;
        write_address_MEM_WB = a;
        final_result         = d;
        trace_ready          = rdy;
        pc_out               = pc;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; Regwrite_MEM_WB = 1'b0;
        write_address_MEM_WB = '0; final_result = '0; trace_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic start(input logic [c_XLEN-1:0] pc);
        enable = 1'b1;
        pc_out = pc;
        Regwrite_MEM_WB = 1'b0;
        tick();
        enable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        chk("rst_state",   state, 2'b00);
        chk("rst_cycle",   cycle_count, 0);
        chk("rst_retire",  retire_count, 0);
        chk("rst_valid",   trace_valid, 0);
        chk("rst_ovf",     overflow, 0);
        chk("rst_done",    done, 0);
        chk("rst_tdata",   trace_data, 0);
        chk("rst_taddr",   trace_addr, 0);

        // ---------------- basic trace, x0 filter ----------------
        start(32'h100);
        chk("start_state", state, 2'b01);
        chk("start_cycle", cycle_count, 0);
        drive(0, 0, 0, 1, 32'h100);
        drive(0, 0, 0, 1, 32'h104);
        drive(1, 1, 5, 1, 32'h108);
        chk("rec1_valid",  trace_valid, 1);
        chk("rec1_cycle",  trace_cycle, 2);
        chk("rec1_addr",   trace_addr, 1);
        chk("rec1_data",   trace_data, 5);
        chk("rec1_retire", retire_count, 1);
        drive(1, 0, 7, 1, 32'h10C);
        chk("x0_valid",    trace_valid, 0);
        chk("x0_retire",   retire_count, 1);
        chk("hold_data",   trace_data, 5);
        drive(1, 3, 12, 1, 32'h110);
        chk("rec2_valid",  trace_valid, 1);
        chk("rec2_cycle",  trace_cycle, 4);
        chk("rec2_addr",   trace_addr, 3);
        chk("rec2_data",   trace_data, 12);
        chk("rec2_retire", retire_count, 2);
        drive(0, 0, 0, 1, 32'h114);
        chk("drain_valid", trace_valid, 0);
        chk("run_cycle6",  cycle_count, 6);

        // ---------------- mid-run asynchronous reset ----------------
        drive(1, 2, 20, 1, 32'h118);
        drive(1, 4, 40, 1, 32'h11C);
        drive(1, 5, 50, 1, 32'h120);
        chk("pre_rst_retire", retire_count, 5);
        reset = 1'b1;
        #1;
        chk("arst_state",  state, 2'b00);
        chk("arst_cycle",  cycle_count, 0);
        chk("arst_retire", retire_count, 0);
        chk("arst_valid",  trace_valid, 0);
        chk("arst_ovf",    overflow, 0);
        do_reset();

        // ---------------- halt detection ----------------
        start(32'h200);
        for (int c = 0; c < 13; c++) begin
            drive(0, 0, 0, 1, (c < 10) ? (32'h200 + 32'(4 * c)) : 32'h40);
        end
        chk("halt_notyet", state, 2'b01);
        drive(1, 7, 32'h99, 0, 32'h40);
        chk("halt_state",  state, 2'b10);
        chk("halt_done",   done, 1);
        chk("halt_cycle",  cycle_count, 14);
        chk("halt_retire", retire_count, 1);
        chk("halt_rec_v",  trace_valid, 1);
        chk("halt_rec_c",  trace_cycle, 13);
        chk("halt_rec_a",  trace_addr, 7);
        enable = 1'b1;
        drive(1, 8, 32'h55, 0, 32'h44);
        drive(1, 8, 32'h55, 0, 32'h48);
        enable = 1'b0;
        chk("halt_term",   state, 2'b10);
        chk("halt_frz_c",  cycle_count, 14);
        chk("halt_frz_r",  retire_count, 1);

        // ---------------- timeout ----------------
        do_reset();
        start(32'h300);
        for (int c = 0; c < 19; c++) begin
            drive(0, 0, 0, 1, 32'h300 + 32'(4 * c));
        end
        chk("to_notyet",   state, 2'b01);
        chk("to_cycle19",  cycle_count, 19);
        drive(0, 0, 0, 1, 32'h300 + 32'(4 * 19));
        chk("to_state",    state, 2'b11);
        chk("to_done",     done, 1);
        chk("to_cycle",    cycle_count, 20);
        drive(0, 0, 0, 1, 32'h400);
        chk("to_frz",      cycle_count, 20);

        // ---------------- halt beats timeout on same edge ----------------
        do_reset();
        start(32'h400);
        for (int c = 0; c < 19; c++) begin
            drive(0, 0, 0, 1, (c < 16) ? (32'h400 + 32'(4 * c)) : 32'h40);
        end
        chk("tie_notyet",  state, 2'b01);
        drive(0, 0, 0, 1, 32'h40);
        chk("tie_state",   state, 2'b10);
        chk("tie_cycle",   cycle_count, 20);

        // ---------------- FIFO overflow and drain ----------------
        do_reset();
        start(32'h500);
        for (int c = 0; c < 10; c++) begin
            drive(1, 5'(c + 1), 32'h1000 + 32'(c), 0, 32'h500 + 32'(4 * c));
            if (c == 7) chk("full_noovf", overflow, 0);
        end
        chk("ovf_set",     overflow, 1);
        chk("ovf_retire",  retire_count, 10);
        for (int i = 0; i < 8; i++) begin
            chk("drn_valid", trace_valid, 1);
            chk("drn_cycle", trace_cycle, 64'(i));
            chk("drn_addr",  trace_addr, 64'(i + 1));
            chk("drn_data",  trace_data, 64'(32'h1000 + i));
            drive(0, 0, 0, 1, 32'h500 + 32'(4 * (10 + i)));
        end
        chk("drn_empty",   trace_valid, 0);
        chk("ovf_sticky",  overflow, 1);

        // ---------------- push while full with simultaneous pop ----------------
        do_reset();
        start(32'h600);
        for (int c = 0; c < 8; c++) begin
            drive(1, 5'(c + 1), 32'h2000 + 32'(c), 0, 32'h600 + 32'(4 * c));
        end
        drive(1, 9, 32'h2008, 1, 32'h620);
        chk("pp_noovf",    overflow, 0);
        chk("pp_retire",   retire_count, 9);
        for (int i = 1; i < 9; i++) begin
            chk("pp_valid", trace_valid, 1);
            chk("pp_cycle", trace_cycle, 64'(i));
            chk("pp_data",  trace_data, 64'(32'h2000 + i));
            drive(0, 0, 0, 1, 32'h624 + 32'(4 * i));
        end
        chk("pp_empty",    trace_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
